// File: rtl/fetch_unit.sv
// fetch_unit: Y86-64 style instruction fetch FSM with registered decoded fields.
// Optional macro FETCH_BOUND_CHECK_EN adds an IMEM_SIZE bound check that reports ADR.
module fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          IMEM_SIZE = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_we,
   input  logic [63:0] new_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic [79:0] imem_rdata,
   input  logic        imem_err,
   output logic [63:0] pc,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic        f_valid,
   output logic [2:0]  stat
);
   typedef enum logic [2:0] {IDLE, REQ, DONE, WAIT_PC, HALT} state_t;
   localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

   state_t      state;
   logic [3:0]  d_icode, d_len;
   logic        has_reg;
   logic [63:0] d_valc, d_valp;
   logic [2:0]  d_stat;

   assign d_icode   = imem_rdata[7:4];
   assign imem_addr = pc;

   always_comb begin
      d_len   = 4'd1;
      has_reg = 1'b0;
      d_valc  = 64'h0;
      case (d_icode)
         4'h2, 4'h6, 4'hA, 4'hB: begin d_len = 4'd2; has_reg = 1'b1; end
         4'h7, 4'h8: begin d_len = 4'd9; d_valc = imem_rdata[71:8]; end
         4'h3, 4'h4, 4'h5: begin d_len = 4'd10; has_reg = 1'b1; d_valc = imem_rdata[79:16]; end
         default: ;
      endcase
   end

   assign d_valp = pc + 64'(d_len);

`ifdef FETCH_BOUND_CHECK_EN
   // 65-bit sum so an instruction straddling 2^64 is still out of bounds
   logic [64:0] end_addr;
   assign end_addr = {1'b0, pc} + 65'(d_len);
   assign d_stat = imem_err ? ADR : (end_addr > 65'(IMEM_SIZE)) ? ADR :
                   (d_icode > 4'hB) ? INS : (d_icode == 4'h0) ? HLT : AOK;
`else
   logic unused_size;
   assign unused_size = ^IMEM_SIZE;
   assign d_stat = imem_err ? ADR : (d_icode > 4'hB) ? INS : (d_icode == 4'h0) ? HLT : AOK;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         imem_req <= 1'b0;
         f_valid  <= 1'b0;
         stat     <= AOK;
         icode    <= 4'h0;
         ifun     <= 4'h0;
         rA       <= 4'hF;
         rB       <= 4'hF;
         valC     <= 64'h0;
         valP     <= 64'h0;
      end else begin
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: if (imem_ready) begin
               icode    <= d_icode;
               ifun     <= imem_rdata[3:0];
               rA       <= has_reg ? imem_rdata[15:12] : 4'hF;
               rB       <= has_reg ? imem_rdata[11:8] : 4'hF;
               valC     <= d_valc;
               valP     <= d_valp;
               stat     <= d_stat;
               imem_req <= 1'b0;
               f_valid  <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               f_valid <= 1'b0;
               state   <= (stat == AOK) ? WAIT_PC : HALT;
            end
            WAIT_PC: if (pc_we) begin
               pc       <= new_pc;
               imem_req <= 1'b1;
               state    <= REQ;
            end
            HALT: state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL provide parameter IMEM_SIZE, default 4096, meaning the instruction memory size in bytes.
REQ-003 SHALL provide port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL provide port pc_we  input  1  when high, load new_pc into the PC (from the downstream PC-update stage).
REQ-006 SHALL provide port new_pc  input  64  next PC value.
REQ-007 SHALL provide port imem_req  output  1  instruction memory read request.
REQ-008 SHALL provide port imem_addr  output  64  read address; equals pc.
REQ-009 SHALL provide port imem_ready  input  1  read data valid; completes the request.
REQ-010 SHALL provide port imem_rdata  input  80  10 bytes at imem_addr; byte0 in [7:0], little-endian.
REQ-011 SHALL provide port imem_err  input  1  qualified by imem_ready; address fault.
REQ-012 SHALL provide port pc  output  64  current PC register.
REQ-013 SHALL provide ports icode  output  4, ifun  output  4, rA  output  4, rB  output  4, valC  output  64, valP  output  64: fields of the fetched instruction.
REQ-014 SHALL provide port f_valid  output  1  single-cycle pulse; fetched fields valid.
REQ-015 SHALL provide port stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DONE, WAIT_PC, HALT.
REQ-017 SHALL transition IDLE->REQ unconditionally one cycle after reset release; imem_req SHALL be high only in REQ.
REQ-018 SHALL hold imem_req and imem_addr stable in REQ until imem_ready; on imem_ready, latch all fields and go to DONE.
REQ-019 SHALL pulse f_valid for exactly the DONE cycle, then enter WAIT_PC if stat=AOK, else HALT.
REQ-020 SHALL decode icode=byte0[7:4], ifun=byte0[3:0], rA=byte1[7:4], rB=byte1[3:0].
REQ-021 SHALL set instruction length by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10.
REQ-022 SHALL set valC = bytes 2..9 for icode 3,4,5; bytes 1..8 for icode 7,8; 0 otherwise.
REQ-023 SHALL set rA=rB=4'hF for icodes without a register byte.
REQ-024 SHALL compute valP = pc + length, modulo 2^64; wrap-around is not an error.
REQ-025 SHALL assign stat with priority: imem_err -> ADR; icode > 4'hB -> INS; icode = 0 -> HLT; else AOK.
REQ-026 SHALL, in WAIT_PC, load pc <= new_pc on pc_we and go to REQ next cycle; pc_we SHALL be ignored in every other state.
REQ-027 SHALL remain in HALT, with outputs frozen and imem_req low, until reset.
REQ-028 SHALL hold all decoded outputs stable between f_valid pulses.

Reset
REQ-029 SHALL, on rst_n low (asynchronous, including mid-request), force state=IDLE, pc=RESET_PC, imem_req=0, f_valid=0, stat=AOK (1), and icode, ifun, valC, valP=0, rA=rB=4'hF.
REQ-030 SHALL abandon an outstanding memory request on reset; a late imem_ready SHALL be ignored outside REQ.

Configuration
REQ-031 SHALL, with macro FETCH_BOUND_CHECK_EN defined, report stat=ADR (priority between imem_err and INS) when pc + length > IMEM_SIZE, computed without 64-bit wrap; without the macro, no bound check SHALL exist and only imem_err yields ADR.

Verification
REQ-032 SHALL cover: reset, then fetch at 0 with bytes 30 F3 0A 00.. (irmovq) and imem_ready after 3 cycles -> icode=3, rB=3, valC=10, valP=10, stat=1, one f_valid pulse.
REQ-033 SHALL cover: in WAIT_PC, pc_we=1 with new_pc=0x40 -> imem_addr=0x40 with imem_req high on the following cycle.
REQ-034 SHALL cover: fetch byte0=0x00 -> stat=2, FSM in HALT, imem_req stays low for 20 cycles despite pc_we pulses.
REQ-035 SHALL cover: byte0=0xC0 -> stat=4; imem_err=1 with byte0=0x10 -> stat=3.
REQ-036 SHALL cover: rst_n low while in REQ -> imem_req=0 immediately, pc=RESET_PC; after release, new fetch from RESET_PC.
REQ-037 SHALL cover: with FETCH_BOUND_CHECK_EN, pc=4090 and icode 3 -> stat=3; without the macro -> stat=1.
